// File: rtl/imem_boot_ctrl_pkg.sv
// Shared definitions for the instruction-memory boot/fetch controller,
// also consumed by the memory wrapper and the core fetch stage.
package imem_boot_ctrl_pkg;

  localparam int          IMEM_BYTES  = 1024;
  localparam int          IMEM_ADDR_W = 10;
  localparam logic [31:0] IMEM_NOP    = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } boot_state_e;

endpackage

// File: rtl/imem_fetch_resp.sv
// Registered instruction-fetch response with alignment/range fault check.
import imem_boot_ctrl_pkg::*;

module imem_fetch_resp #(
  parameter int          MEM_BYTES = IMEM_BYTES,
  parameter logic [31:0] NOP_INSTR = IMEM_NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] rdata_i,
  output logic        valid_o,
  output logic        fault_o,
  output logic [31:0] instr_o
);

  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [31:0] instr_q, instr_d;
  logic        addr_bad;

  // Upper address bits beyond the memory are caught by the full-width compare.
  assign addr_bad = (addr_i[1:0] != 2'b00) || (addr_i > 32'(MEM_BYTES - 4));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    valid_d = req_i;
    fault_d = 1'b0;
    instr_d = instr_q;
    if (req_i) begin
      fault_d = addr_bad;
      instr_d = addr_bad ? NOP_INSTR : rdata_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else begin
      valid_q <= valid_d;
      fault_q <= fault_d;
      instr_q <= instr_d;
    end
  end

  assign valid_o = valid_q;
  assign fault_o = fault_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot/fetch controller: streams a program image into the instruction memory
// while holding the CPU, then serves registered instruction fetches.
import imem_boot_ctrl_pkg::*;

module imem_boot_ctrl #(
  parameter int          MEM_BYTES = IMEM_BYTES,
  parameter int          ADDR_W    = IMEM_ADDR_W,
  parameter logic [31:0] NOP_INSTR = IMEM_NOP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              run_start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_valid,
  output logic [31:0]       fetch_instr,
  output logic              fetch_fault,
  output logic              cpu_hold,
  output logic              load_busy
);

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(MEM_BYTES);

  boot_state_e     state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [ADDR_W:0] len_clamped;
  logic            start_load;
  logic            fetch_en;

  assign len_clamped = (load_len > MAX_LEN) ? MAX_LEN : load_len;
  // A load may start from HOLD or RUN; a repeated start mid-load is ignored.
  assign start_load  = load_start && (state_q != ST_LOAD);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    s_ready  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    fetch_en = 1'b0;

    unique case (state_q)
      ST_HOLD: begin
        if (run_start) state_d = ST_RUN;
      end
      ST_LOAD: begin
        s_ready  = 1'b1;
        mem_addr = cnt_q[ADDR_W-1:0];
        mem_we   = s_valid;
        if (s_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == len_q - 1'b1) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        mem_addr = fetch_addr[ADDR_W-1:0];
        fetch_en = fetch_req;
      end
      default: state_d = ST_HOLD;
    endcase

    // Overrides run_start in HOLD; a zero-length image releases the CPU at once.
    if (start_load) begin
      len_d   = len_clamped;
      cnt_d   = '0;
      state_d = (len_clamped == '0) ? ST_RUN : ST_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  assign mem_wdata = s_data;
  assign cpu_hold  = (state_q != ST_RUN);
  assign load_busy = (state_q == ST_LOAD);

  imem_fetch_resp #(
    .MEM_BYTES (MEM_BYTES),
    .NOP_INSTR (NOP_INSTR)
  ) u_fetch_resp (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (fetch_en),
    .addr_i  (fetch_addr),
    .rdata_i (mem_rdata),
    .valid_o (fetch_valid),
    .fault_o (fetch_fault),
    .instr_o (fetch_instr)
  );

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
Boot and fetch controller for the byte-addressed instruction memory (1024 bytes, 32-bit combinational read, big-endian word assembly {m[a],m[a+1],m[a+2],m[a+3]}).
- Loads a program image from a byte stream (UART or debug link) into the memory's byte write port.
- Holds the CPU while loading.
- Serves CPU instruction fetches with a registered one-cycle response.
- Sits between the memory, the loader link and the core's fetch stage.

Parameters:
MEM_BYTES, 1024, instruction memory size in bytes (power of two).
ADDR_W, 10, byte address width, log2(MEM_BYTES).
NOP_INSTR, 32'h00000013, word returned on a faulted fetch (addi x0,x0,0).

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
load_start  in  1  pulse: begin a load of load_len bytes.
load_len  in  ADDR_W+1  image length in bytes, sampled on load_start.
run_start  in  1  pulse: release the CPU without loading.
s_valid  in  1  loader byte valid.
s_data  in  8  loader byte.
s_ready  out  1  loader byte accepted when s_valid&&s_ready.
mem_addr  out  ADDR_W  memory byte address (read and write).
mem_we  out  1  byte write enable.
mem_wdata  out  8  write byte.
mem_rdata  in  32  memory read word at mem_addr (combinational).
fetch_req  in  1  CPU fetch request.
fetch_addr  in  32  CPU fetch byte address.
fetch_valid  out  1  fetch response valid.
fetch_instr  out  32  fetched instruction.
fetch_fault  out  1  response is for a misaligned or out-of-range address.
cpu_hold  out  1  CPU must stall/hold PC.
load_busy  out  1  in LOAD state.

Behaviour:
- Reset (async, rst_n=0): state=HOLD.
  - cpu_hold=1; s_ready=0; mem_we=0; fetch_valid=0; fetch_fault=0; load_busy=0.
  - fetch_instr=NOP_INSTR; byte counter=0; latched length=0.
- States HOLD, LOAD, RUN. cpu_hold=1 in HOLD and LOAD, 0 in RUN. load_busy=1 only in LOAD.
- Transitions from HOLD:
  - load_start -> LOAD.
  - run_start -> RUN.
  - Both asserted in the same cycle: load_start wins.
- Load setup: on load_start, latch len=min(load_len, MEM_BYTES) and clear the counter.
  - If len==0, go directly to RUN and accept no bytes.
- LOAD state:
  - s_ready=1; mem_addr=counter; mem_wdata=s_data; mem_we=s_valid (combinational).
  - Each accepted byte increments the counter.
  - On acceptance of byte len-1, go to RUN on the next edge; s_ready is 0 from that edge.
  - Bytes beyond len are never accepted.
  - load_start during LOAD is ignored.
- RUN state:
  - load_start -> LOAD (re-load). Any in-flight fetch response still completes in the following cycle.
  - run_start is ignored.
- Fetch (RUN only):
  - mem_addr=fetch_addr[ADDR_W-1:0] combinationally.
  - On fetch_req, the next edge sets fetch_valid=1 and fetch_instr=mem_rdata, with fetch_fault=0.
  - Latency is 1 cycle. Back-to-back requests give one response per cycle.
  - fetch_valid deasserts the cycle after fetch_req drops.
- Fault: fetch_addr[1:0]!=0 or fetch_addr>MEM_BYTES-4, including any upper bits set.
  - The response is fetch_valid=1, fetch_fault=1, fetch_instr=NOP_INSTR.
- fetch_req outside RUN is ignored: fetch_valid=0.
- mem_addr in HOLD is 0.
- mem_we is never asserted outside LOAD.
- Reset mid-load: the load aborts immediately to HOLD. Partially written bytes remain in memory. The counter clears.
- Counter width is ADDR_W+1 so that len==MEM_BYTES terminates without wrap.

Decomposition:
- Shared package holds:
  - the state enum (HOLD/LOAD/RUN);
  - NOP_INSTR;
  - the MEM_BYTES/ADDR_W defaults, shared with the memory and the core fetch stage.
- One sub-module is natural: imem_fetch_resp.
  - Registered fetch response with fault check.
  - Instantiated once.
  - The FSM and loader counter stay in the top.

Test Plan:
- Reset then run_start, no load -> cpu_hold 1→0 next edge. fetch_req addr 0x0 gives fetch_valid=1 one cycle later, fetch_instr=memory word at 0.
- load_start len=8, stream bytes 00 14 05 93 00 30 06 13 with s_valid gaps -> mem_we pulses at addresses 0..7.
  - cpu_hold stays 1 until the 8th byte, then RUN.
  - Fetches at 0 and 4 return 0x00140593 and 0x00300613.
- Fetch addr 0x2 and 0x3FE and 0x400 -> fetch_valid=1, fetch_fault=1, fetch_instr=0x00000013, 1 cycle after each.
- load_len=0 -> RUN the next cycle, s_ready never 1.
- load_len=2000 -> clamped to 1024: exactly 1024 bytes accepted, last write at 0x3FF, then RUN.
- rst_n low after 3 of 8 bytes -> async return to HOLD, all outputs at reset values.
  - A new load_start then writes from address 0.
